// File: rtl/slice_byte_packer.sv
// Packs 0..8 byte bursts from set_bit big-endian into 32-bit words, buffers them in a FIFO and
// closes each slice with padding and a byte count. Optional trailer word: SLICE_PACK_TRAILER_EN.
module slice_byte_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       in_byte_count,
  input  logic [63:0]      in_val,
  input  logic             slice_end,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] slice_size,
  output logic             slice_done,
  output logic             overflow
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthW  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ReadyLim = DepthW - (AW+1)'(3);

  typedef enum logic [2:0] {StIdle, StRun, StPad, StTrail, StDone} state_e;

`ifdef SLICE_PACK_TRAILER_EN
  localparam state_e PadNext = StTrail;
`else
  localparam state_e PadNext = StDone;
`endif

  state_e state_q, state_d;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [23:0]      res_q, res_d;
  logic [1:0]       res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] slice_size_q;
  logic             slice_done_q, overflow_q, in_ready_q;

  logic [3:0]       nbytes;
  logic [63:0]      in_mask;
  logic [87:0]      cat, shifted;
  logic [3:0]       total;
  logic [1:0]       npush;
  logic             pop;
  logic [AW+1:0]    free_eff;
  logic             push0, push1, drop, done_set;
  logic [31:0]      wd0, wd1;

`ifdef SLICE_PACK_TRAILER_EN
  logic [31:0] cnt_ext;
  assign cnt_ext = 32'(cnt_q);
`endif

  assign nbytes  = (in_byte_count > 4'd8) ? 4'd8 : in_byte_count;
  // Zero the unused low bytes so stale data never leaks into words or padding.
  assign in_mask = ~({64{1'b1}} >> {nbytes, 3'b000});
  assign cat     = {res_q, 64'h0} | ({in_val & in_mask, 24'h0} >> {res_cnt_q, 3'b000});
  assign total   = {2'b00, res_cnt_q} + nbytes;
  assign npush   = total[3:2];
  assign shifted = cat << {npush, 5'b00000};

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem[rd_ptr_q] : 32'h0;
  assign pop        = out_valid & out_ready;
  assign free_eff   = {1'b0, DepthW} - {1'b0, count_q} + {{(AW+1){1'b0}}, pop};
  assign in_ready   = in_ready_q;
  assign slice_size = slice_size_q;
  assign slice_done = slice_done_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    cnt_d     = cnt_q;
    push0     = 1'b0;
    push1     = 1'b0;
    drop      = 1'b0;
    done_set  = 1'b0;
    wd0       = cat[87:56];
    wd1       = cat[55:24];
    unique case (state_q)
      StIdle, StRun: begin
        res_d     = shifted[87:64];
        res_cnt_d = total[1:0];
        cnt_d     = cnt_q + CNT_W'(nbytes);
        if (npush != 2'd0) begin
          if (free_eff >= (AW+2)'(1)) push0 = 1'b1;
          else                        drop  = 1'b1;
        end
        if (npush == 2'd2) begin
          if (free_eff >= (AW+2)'(2)) push1 = 1'b1;
          else                        drop  = 1'b1;
        end
        if (slice_end)           state_d = StPad;
        else if (nbytes != 4'd0) state_d = StRun;
      end
      StPad: begin
        drop = (in_byte_count != 4'd0);
        if (res_cnt_q == 2'd0) begin
          state_d = PadNext;
        end else if (free_eff != '0) begin
          push0     = 1'b1;
          wd0       = {res_q, 8'h00};
          res_d     = '0;
          res_cnt_d = '0;
          state_d   = PadNext;
        end
      end
`ifdef SLICE_PACK_TRAILER_EN
      StTrail: begin
        drop = (in_byte_count != 4'd0);
        if (free_eff != '0) begin
          push0   = 1'b1;
          wd0     = {16'hA5A5, cnt_ext[15:0]};
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        drop      = (in_byte_count != 4'd0);
        done_set  = 1'b1;
        cnt_d     = '0;
        res_d     = '0;
        res_cnt_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign count_d = count_q + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push0) mem[wr_ptr_q] <= wd0;
    if (push1) mem[wr_ptr_q + AW'(1)] <= wd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_q        <= '0;
      res_cnt_q    <= '0;
      cnt_q        <= '0;
      slice_size_q <= '0;
      slice_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_q + AW'(push0) + AW'(push1);
      rd_ptr_q     <= rd_ptr_q + AW'(pop);
      count_q      <= count_d;
      res_q        <= res_d;
      res_cnt_q    <= res_cnt_d;
      cnt_q        <= cnt_d;
      slice_done_q <= done_set;
      if (done_set) slice_size_q <= cnt_q;
      if (drop)     overflow_q   <= 1'b1;
      in_ready_q   <= (count_d <= ReadyLim);
    end
  end

endmodule

// File: tb/tb_slice_byte_packer.sv
// Self-checking bench for slice_byte_packer: vector table, hand-written corner sequences and a
// randomised stream, all compared through a word/size scoreboard.
module tb_slice_byte_packer;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       in_byte_count = '0;
  logic [63:0]      in_val = '0;
  logic             slice_end = 1'b0;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] slice_size;
  logic             slice_done;
  logic             overflow;

  slice_byte_packer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_byte_count(in_byte_count), .in_val(in_val),
    .slice_end(slice_end), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .slice_size(slice_size), .slice_done(slice_done),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  cnt;
    logic [63:0] val;
    logic        send;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [15:0] size;
  } vec_t;

  vec_t tbl [10];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  logic [31:0]      exp_words [$];
  logic [CNT_W-1:0] exp_sizes [$];
  logic [7:0]       bq [$];
  int               slice_bytes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Called at a negedge with inputs set: scores the handshake of the coming edge, then advances.
  task automatic tick();
    if (reset_n && out_valid && out_ready) begin
      if (exp_words.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        check("word", out_data, exp_words.pop_front());
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (reset_n && slice_done) begin
      done_cnt++;
      if (exp_sizes.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got size %0d expected no pulse", slice_size);
      end else begin
        check("slice_size", slice_size, exp_sizes.pop_front());
      end
    end
  endtask

  task automatic model_bytes(input logic [3:0] cnt, input logic [63:0] val);
    int n = (cnt > 4'd8) ? 8 : int'(cnt);
    logic [31:0] w;
    for (int k = 0; k < n; k++) bq.push_back(val[63-8*k -: 8]);
    slice_bytes += n;
    while (bq.size() >= 4) begin
      w = {bq[0], bq[1], bq[2], bq[3]};
      repeat (4) void'(bq.pop_front());
      exp_words.push_back(w);
    end
  endtask

  task automatic model_end();
    logic [31:0] w;
    if (bq.size() > 0) begin
      while (bq.size() < 4) bq.push_back(8'h00);
      w = {bq[0], bq[1], bq[2], bq[3]};
      bq.delete();
      exp_words.push_back(w);
    end
`ifdef SLICE_PACK_TRAILER_EN
    exp_words.push_back({16'hA5A5, 16'(slice_bytes)});
`endif
    exp_sizes.push_back(CNT_W'(slice_bytes));
    slice_bytes = 0;
  endtask

  task automatic drive(input logic [3:0] cnt, input logic [63:0] val, input logic send);
    in_byte_count = cnt;
    in_val        = val;
    slice_end     = send;
    tick();
    in_byte_count = '0;
    in_val        = '0;
    slice_end     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = done_cnt;
    for (int i = 0; i < 64 && done_cnt == start; i++) tick();
    checks++;
    if (done_cnt != start) passes++;
    else $display("FAIL %s: got no slice_done expected one within 64 cycles", name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_words.size() > 0; i++) tick();
    check(name, 64'(exp_words.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bq.delete();
    exp_words.delete();
    exp_sizes.delete();
    slice_bytes = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] v;
    int d0;

    tbl[0] = '{4'd8,  64'h0102030405060708, 1'b0, 2, 32'h01020304, 32'h05060708, 16'd0};
    tbl[1] = '{4'd0,  64'h0,                1'b1, 0, 32'h0,        32'h0,        16'd8};
    tbl[2] = '{4'd3,  64'hAABBCCDDEEFF1122, 1'b1, 1, 32'hAABBCC00, 32'h0,        16'd3};
    tbl[3] = '{4'd5,  64'hA1A2A3A4A5FFFFFF, 1'b0, 1, 32'hA1A2A3A4, 32'h0,        16'd0};
    tbl[4] = '{4'd7,  64'hB1B2B3B4B5B6B7EE, 1'b0, 2, 32'hA5B1B2B3, 32'hB4B5B6B7, 16'd0};
    tbl[5] = '{4'd15, 64'hC1C2C3C4C5C6C7C8, 1'b0, 2, 32'hC1C2C3C4, 32'hC5C6C7C8, 16'd0};
    tbl[6] = '{4'd2,  64'hD1D2FFFFFFFFFFFF, 1'b1, 1, 32'hD1D20000, 32'h0,        16'd22};
    tbl[7] = '{4'd0,  64'h0,                1'b1, 0, 32'h0,        32'h0,        16'd0};
    tbl[8] = '{4'd6,  64'hE1E2E3E4E5E69999, 1'b0, 1, 32'hE1E2E3E4, 32'h0,        16'd0};
    tbl[9] = '{4'd1,  64'hF177777777777777, 1'b1, 1, 32'hE5E6F100, 32'h0,        16'd7};

    // Reset state
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_slice_size", slice_size, 0);
    check("rst_slice_done", slice_done, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("in_ready_after_rst", in_ready, 1);

    // Four single bytes form one word, visible one cycle after the fourth byte
    out_ready = 1'b1;
    model_bytes(4'd1, 64'h1100000000000000); drive(4'd1, 64'h1100000000000000, 1'b0);
    model_bytes(4'd1, 64'h2200000000000000); drive(4'd1, 64'h2200000000000000, 1'b0);
    model_bytes(4'd1, 64'h3300000000000000); drive(4'd1, 64'h3300000000000000, 1'b0);
    check("single_no_word_yet", out_valid, 0);
    model_bytes(4'd1, 64'h4400000000000000); drive(4'd1, 64'h4400000000000000, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 32'h11223344);
    tick();
    check("single_valid_one_cycle", out_valid, 0);
    model_end();
    drive(4'd0, 64'h0, 1'b1);
    wait_done("single_done");

    // Vector table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].nw > 0) exp_words.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) exp_words.push_back(tbl[i].w1);
      if (tbl[i].send) begin
`ifdef SLICE_PACK_TRAILER_EN
        exp_words.push_back({16'hA5A5, tbl[i].size});
`endif
        exp_sizes.push_back(CNT_W'(tbl[i].size));
      end
      drive(tbl[i].cnt, tbl[i].val, tbl[i].send);
      if (tbl[i].send) wait_done("tbl_done");
    end
    drain("tbl_drain");
    check("tbl_no_overflow", overflow, 0);

    // Fill with consumer stalled until in_ready falls, then force two more cycles
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 8; k++) v[63-8*k -: 8] = 8'(i * 8 + k + 1);
      if (i < 7) check("in_ready_fill", in_ready, 1);
      if (i < 8) model_bytes(4'd8, v);
      drive(4'd8, v, 1'b0);
      if (i == 6) check("in_ready_low_at_14", in_ready, 0);
      if (i == 7) check("no_overflow_when_full", overflow, 0);
      if (i == 8) check("overflow_set", overflow, 1);
    end
    out_ready = 1'b1;
    drain("ovf_drain");
    check("overflow_sticky", overflow, 1);
    do_reset();
    tick();
    check("overflow_cleared_by_reset", overflow, 0);

    // Reset while the FIFO holds five words
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = {32'(32'h5000_0000 + i), 32'h0};
      model_bytes(4'd4, v);
      drive(4'd4, v, 1'b0);
    end
    check("five_words_valid", out_valid, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    do_reset();
    repeat (3) tick();
    check("mid_reset_slice_size", slice_size, 0);
    check("mid_reset_no_done", done_cnt, d0);

    // Random stream with random back-pressure
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] c;
      out_ready = ($urandom_range(0, 3) != 0);
      c = in_ready ? 4'($urandom_range(0, 8)) : 4'd0;
      v = {$urandom, $urandom};
      model_bytes(c, v);
      drive(c, v, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    v = {$urandom, $urandom};
    model_bytes(4'd5, v);
    model_end();
    drive(4'd5, v, 1'b1);
    wait_done("rand_done");
    drain("rand_drain");
    check("rand_no_overflow", overflow, 0);
    check("rand_sizes_consumed", 64'(exp_sizes.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
